mem_copy_dma: RTL and testbench
===============================

# mem_copy_dma

Sequential initiator for the word-addressed, combinational-read data memory. It copies a block of `length` 32-bit words from `src_addr` to `dst_addr` by driving the memory's address, write-data and read/write lines. Overlapping copies follow memmove semantics. It sits between the control unit, which issues `start` and waits for `done` or `error`, and the data memory port.

## Interface
- `ADDR_W`, 32, width of address ports.
- `DATA_W`, 32, word width.
- `MEM_DEPTH`, 128, number of words in the attached memory.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a copy; sampled only in IDLE.
- `src_addr`  in  ADDR_W  first source word address.
- `dst_addr`  in  ADDR_W  first destination word address.
- `length`  in  8  number of words to copy (0..255).
- `busy`  out  1  high from the accepting edge until the DONE cycle.
- `done`  out  1  one-cycle pulse, copy finished or length 0.
- `error`  out  1  one-cycle pulse, request rejected because it is out of range.
- `mem_address`  out  ADDR_W  memory address, registered.
- `mem_wdata`  out  DATA_W  to memory write data, registered.
- `mem_rw`  out  1  memory read/write: 1 = write, 0 = read. Registered and glitch-free.
- `mem_rdata`  in  DATA_W  from memory read data. Valid combinationally in the same cycle as `mem_address`.

## Operation
- **States:** IDLE, READ, WRITE, DONE, ERR.
- **Reset values:** all outputs 0. State is IDLE and internal counters are 0.
- **IDLE:**
  - `start`=0: stay in IDLE.
  - `start`=1: latch `src_addr`, `dst_addr` and `length`, then evaluate in this order:
    - Either `src_addr+length` or `dst_addr+length` exceeds `MEM_DEPTH`: go to ERR. Sums use ADDR_W+1 bits, so they never wrap.
    - `length`==0: go to DONE.
    - Otherwise go to READ with `busy`=1.
- **Direction:**
  - `dst_addr` > `src_addr`: copy descending, last word first (index `length`-1 down to 0).
  - Otherwise: copy ascending (index 0 up).
  - `dst_addr`==`src_addr`: the copy is still performed, ascending.
- **READ:**
  - Outputs `mem_rw`=0, `mem_address`=src+i.
  - At the edge, capture `mem_rdata` into the word buffer, then go to WRITE.
- **WRITE:**
  - Outputs `mem_rw`=1, `mem_address`=dst+i, `mem_wdata`=buffer.
  - At the edge: if this was the last word, go to DONE; otherwise step i and go to READ.
- **DONE:** `done`=1, `busy`=0, `mem_rw`=0. Next state is IDLE.
- **ERR:** `error`=1, `busy`=0, `mem_rw`=0, and no memory access is made. Next state is IDLE.
- **Write-enable hygiene:** `mem_rw` is 1 only in WRITE cycles. `mem_address` and `mem_rw` update on the same edge. No write may occur to any address outside [dst, dst+length).
- **start outside IDLE:** ignored while `busy`, DONE or ERR. A held `start` re-triggers in IDLE.
- **Reset mid-copy:** outputs return to reset values immediately, with no completion pulse. Words already written stay written.

## Timing
- **Request accepted at edge k:**
  - Cycles k..k+2N-1 alternate READ and WRITE; the first cycle is READ.
  - `done` is high during cycle k+2N.
  - `busy` is high during cycles k..k+2N-1.
- **Length 0:** `done` is high during cycle k and `busy` stays 0.
- **Rejected request:** `error` is high during cycle k and `busy` stays 0.
- **Throughput:** 2 cycles per word.
- **Back-to-back:** the earliest next accept is the edge ending the DONE or ERR cycle plus one (the IDLE cycle).

## Test plan
- **Basic ascending copy:** memory[10..13]=A,B,C,D; start with src=10, dst=40, len=4.
  - Required: memory[40..43]=A,B,C,D.
  - `done` pulses exactly 9 edges after start (8 busy cycles).
  - Exactly 4 `mem_rw` pulses, at addresses 40,41,42,43.
- **Forward overlap:** memory[20..23]=1,2,3,4; src=20, dst=21, len=4.
  - Required: memory[21..24]=1,2,3,4.
  - Write addresses appear in the order 24,23,22,21.
- **Length 0 and range errors:**
  - len=0: `done` the cycle after start, zero writes.
  - src=126, len=3: `error` pulse, zero writes, memory unchanged.
  - dst=128, len=1: `error` pulse.
- **Reset mid-copy:** src=0, dst=64, len=8; assert `rst_n`=0 after the 3rd write cycle.
  - Required: `mem_rw`=0 immediately, all outputs 0, no `done`.
  - memory[64..66] copied; memory[67..71] untouched.
- **start while busy:** start len=4, then pulse `start` with a different src/dst during the copy.
  - Required: the second request is ignored and only the first copy happens.
  - Holding `start` high through DONE starts a new copy from IDLE using the then-current inputs.

Source files
------------

// File: rtl/mem_copy_dma_if.sv
// Control-unit request/response and data-memory port bundle for mem_copy_dma.
// slave = the copy engine's view, master = control unit plus memory.
interface mem_copy_dma_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [7:0]        length;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rw;

  modport slave (
    input  start, src_addr, dst_addr, length, mem_rdata,
    output busy, done, error, mem_address, mem_wdata, mem_rw
  );

  modport master (
    output start, src_addr, dst_addr, length, mem_rdata,
    input  busy, done, error, mem_address, mem_wdata, mem_rw
  );
endinterface

// File: rtl/mem_copy_dma.sv
// Word-by-word memmove engine for a combinational-read memory: 2 cycles per word
// (READ then WRITE), one-cycle done/error pulse; start is only sampled in IDLE.
module mem_copy_dma #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_copy_dma_if.slave bus
);
  localparam int SUM_W = ADDR_W + 1;

  typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [7:0]        idx;
  logic [7:0]        remaining;
  logic              descending;
  logic [DATA_W-1:0] buffer;

  logic [SUM_W-1:0]  src_end;
  logic [SUM_W-1:0]  dst_end;
  logic              out_of_range;
  logic [7:0]        first_idx;
  logic [7:0]        next_idx;

  // One extra bit on the end addresses so a request near the top of the address space can't wrap into range.
  assign src_end      = {1'b0, bus.src_addr} + SUM_W'(bus.length);
  assign dst_end      = {1'b0, bus.dst_addr} + SUM_W'(bus.length);
  assign out_of_range = (src_end > SUM_W'(MEM_DEPTH)) || (dst_end > SUM_W'(MEM_DEPTH));
  assign first_idx    = (bus.dst_addr > bus.src_addr) ? bus.length - 8'd1 : 8'd0;
  assign next_idx     = descending ? idx - 8'd1 : idx + 8'd1;
  assign bus.mem_wdata = buffer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      src_q           <= '0;
      dst_q           <= '0;
      idx             <= '0;
      remaining       <= '0;
      descending      <= 1'b0;
      buffer          <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.error       <= 1'b0;
      bus.mem_rw      <= 1'b0;
      bus.mem_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            src_q      <= bus.src_addr;
            dst_q      <= bus.dst_addr;
            remaining  <= bus.length;
            descending <= bus.dst_addr > bus.src_addr;
            idx        <= first_idx;
            if (out_of_range) begin
              state     <= ERR;
              bus.error <= 1'b1;
            end else if (bus.length == 8'd0) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              state           <= READ;
              bus.busy        <= 1'b1;
              bus.mem_address <= bus.src_addr + ADDR_W'(first_idx);
            end
          end
        end
        READ: begin
          buffer          <= bus.mem_rdata;
          bus.mem_rw      <= 1'b1;
          bus.mem_address <= dst_q + ADDR_W'(idx);
          state           <= WRITE;
        end
        WRITE: begin
          bus.mem_rw <= 1'b0;
          if (remaining == 8'd1) begin
            state           <= DONE;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b1;
            bus.mem_address <= '0;
          end else begin
            idx             <= next_idx;
            remaining       <= remaining - 8'd1;
            bus.mem_address <= src_q + ADDR_W'(next_idx);
            state           <= READ;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        ERR: begin
          bus.error <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_copy_dma.sv
// Scoreboard bench for mem_copy_dma: a memmove reference model queues expected writes and
// completion pulses with their cycle numbers; a negedge monitor pops and compares them.
module tb_mem_copy_dma;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_copy_dma_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mem_copy_dma #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  assign bus.mem_rdata = (bus.mem_address < DEPTH) ? mem[bus.mem_address[6:0]] : '0;

  always @(posedge clk)
    if (bus.mem_rw && bus.mem_address < DEPTH) mem[bus.mem_address[6:0]] = bus.mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { logic [63:0] addr; logic [DW-1:0] data; int cyc; } wr_t;
  typedef struct { logic [1:0] kind; int cyc; } cm_t;   // kind = {error, done}

  wr_t wq[$];
  cm_t cq[$];
  int  b_lo = 1;
  int  b_hi = 0;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: memmove of a pre-copy snapshot; only the first nw words of the copy order are written.
  task automatic model(input longint src, input longint dst, input int len, input int k,
                       input int nw, output int e);
    logic [DW-1:0] snap[$];
    if (src + len > DEPTH || dst + len > DEPTH) begin
      cq.push_back('{kind: 2'b10, cyc: k});
      e = k;
      return;
    end
    if (len == 0) begin
      cq.push_back('{kind: 2'b01, cyc: k});
      e = k;
      return;
    end
    for (int i = 0; i < len; i++) snap.push_back(ref_mem[src + i]);
    for (int j = 0; j < len; j++) begin
      int i;
      i = (dst > src) ? len - 1 - j : j;
      if (j < nw) begin
        wq.push_back('{addr: 64'(dst + i), data: snap[i], cyc: k + 2 * j + 1});
        ref_mem[dst + i] = snap[i];
      end
    end
    b_lo = k;
    b_hi = k + 2 * len - 1;
    e    = k + 2 * len;
    if (nw >= len) cq.push_back('{kind: 2'b01, cyc: e});
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drive(input longint src, input longint dst, input int len);
    bus.src_addr = AW'(src);
    bus.dst_addr = AW'(dst);
    bus.length   = 8'(len);
    bus.start    = 1'b1;
  endtask

  task automatic drain();
    chk("writes_left", 64'(wq.size()), 64'd0);
    chk("completions_left", 64'(cq.size()), 64'd0);
    wq.delete();
    cq.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_error"}, 64'(bus.error), 64'd0);
    chk({tag, "_mem_rw"}, 64'(bus.mem_rw), 64'd0);
    chk({tag, "_mem_address"}, 64'(bus.mem_address), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
  endtask

  // Single request, start held for exactly the accepting edge; returns at the IDLE cycle.
  task automatic req(input longint src, input longint dst, input int len);
    int e;
    drive(src, dst, len);
    model(src, dst, len, cyc + 1, len, e);
    @(negedge clk);
    bus.start = 1'b0;
    wait_cyc(e + 1);
    drain();
  endtask

  always @(negedge clk) begin
    wr_t w;
    cm_t c;
    if (rst_n) begin
      chk("busy", 64'(bus.busy), 64'(cyc >= b_lo && cyc <= b_hi));
      if (bus.mem_rw) begin
        if (wq.size() == 0) chk("unexpected_write", 64'(bus.mem_address), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          w = wq.pop_front();
          chk("wr_addr", 64'(bus.mem_address), w.addr);
          chk("wr_data", 64'(bus.mem_wdata), 64'(w.data));
          chk("wr_cycle", 64'(cyc), 64'(w.cyc));
        end
      end
      if (bus.done || bus.error) begin
        if (cq.size() == 0) chk("unexpected_pulse", 64'({bus.error, bus.done}), 64'd0);
        else begin
          c = cq.pop_front();
          chk("pulse_kind", 64'({bus.error, bus.done}), 64'(c.kind));
          chk("pulse_cycle", 64'(cyc), 64'(c.cyc));
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: no finish within budget, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, e, e2;
    bus.start    = 1'b0;
    bus.src_addr = '0;
    bus.dst_addr = '0;
    bus.length   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    check_zero("reset");
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Basic ascending copy and forward overlap
    for (int i = 0; i < 4; i++) begin
      mem[10 + i] = 32'hA0A0_0000 + i;
      ref_mem[10 + i] = mem[10 + i];
      mem[20 + i] = i + 1;
      ref_mem[20 + i] = mem[20 + i];
    end
    req(10, 40, 4);
    req(20, 21, 4);

    // Length zero, range limits, equal and backward-overlap copies
    req(5, 50, 0);
    req(128, 128, 0);
    req(126, 0, 3);
    req(0, 128, 1);
    req(124, 0, 4);
    req(0, 124, 4);
    req(0, 0, 255);
    req(64'hFFFF_FFFF, 0, 1);
    req(30, 30, 3);
    req(40, 35, 5);

    // Reset during the fourth READ, after three words have been written
    drive(0, 64, 8);
    k = cyc + 1;
    model(0, 64, 8, k, 3, e);
    b_hi = k + 6;
    @(negedge clk);
    bus.start = 1'b0;
    wait_cyc(k + 6);
    #2 rst_n = 1'b0;
    #1 check_zero("mid_reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    b_lo = 1;
    b_hi = 0;
    @(negedge clk);
    drain();

    // start pulses while busy and during DONE are ignored
    drive(70, 90, 4);
    k = cyc + 1;
    model(70, 90, 4, k, 4, e);
    @(negedge clk);
    bus.start = 1'b0;
    wait_cyc(k + 2);
    drive(1, 2, 5);
    @(negedge clk);
    bus.start = 1'b0;
    wait_cyc(e);
    drive(3, 4, 2);
    @(negedge clk);
    bus.start = 1'b0;
    wait_cyc(e + 1);
    drain();

    // Held start re-triggers from IDLE with the inputs present at that time
    drive(100, 80, 3);
    k = cyc + 1;
    model(100, 80, 3, k, 3, e);
    wait_cyc(e);
    drive(80, 82, 3);
    model(80, 82, 3, e + 2, 3, e2);
    wait_cyc(e + 2);
    bus.start = 1'b0;
    wait_cyc(e2 + 1);
    drain();

    for (int t = 0; t < 40; t++) begin
      int mode, len, delta, base;
      longint s, d;
      mode = $urandom_range(0, 9);
      case (mode)
        0: begin
          s = $urandom_range(0, 200);
          d = $urandom_range(0, 200);
          len = $urandom_range(0, 255);
        end
        1: begin
          s = $urandom_range(0, 127);
          d = $urandom_range(0, 127);
          len = 0;
        end
        2, 3, 4: begin
          len = $urandom_range(1, 24);
          delta = $urandom_range(0, len);
          base = $urandom_range(0, DEPTH - len - delta);
          if ($urandom_range(0, 1) == 1) begin
            s = base;
            d = base + delta;
          end else begin
            s = base + delta;
            d = base;
          end
        end
        default: begin
          len = $urandom_range(1, 24);
          s = $urandom_range(0, DEPTH - len);
          d = $urandom_range(0, DEPTH - len);
        end
      endcase
      req(s, d, len);
    end

    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) chk("final_mem", 64'(mem[i]), 64'(ref_mem[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
